pcm_dsm_stereo: RTL and testbench



---
 rtl/pcm_dsm_stereo.sv | 95 +++++++++
 tb/tb_pcm_dsm_stereo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pcm_dsm_stereo.sv
// pcm_dsm_stereo: stereo second-order 1-bit delta-sigma modulator with saturating integrators.
// Optional TPDF dither from a shared 32-bit LFSR when DSM_DITHER_EN is defined.
module pcm_dsm_stereo #(
   parameter int IN_W  = 24,
   parameter int ACC_W = 28
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_l_i,
   input  logic        data_l_stb_i,
   input  logic [31:0] data_r_i,
   input  logic        data_r_stb_i,
   input  logic        dsm_stb_i,
   input  logic        mute_i,
   output logic [1:0]  dsm_o,
   output logic        dsm_valid_o,
   output logic [1:0]  ovl_o
);
   localparam logic [ACC_W:0] FS = (ACC_W+1)'(1) << (IN_W-1);

   logic [1:0][IN_W-1:0]  r_hold;
   logic [1:0][ACC_W-1:0] r_i1, r_i2;
   logic [1:0]            r_dsm, r_ovl;
   logic                  r_valid;
   logic [1:0][31:0]      w_data;
   logic [1:0]            w_cap;
   logic [1:0][ACC_W:0]   w_x, w_fb, w_s1, w_s2;
   logic [1:0][ACC_W-1:0] w_n1, w_n2;
   logic [1:0]            w_o1, w_o2;
   logic [ACC_W:0]        w_dith;
   logic                  w_unused;

   assign w_data   = {data_r_i, data_l_i};
   assign w_cap    = {data_r_stb_i, data_l_stb_i};
   assign w_unused = ^{data_l_i[31-IN_W:0], data_r_i[31-IN_W:0], r_hold[0][0], r_hold[1][0]};

`ifdef DSM_DITHER_EN
   logic [31:0] r_lfsr;
   logic [8:0]  w_d;
   assign w_d    = {1'b0, r_lfsr[7:0]} - {1'b0, r_lfsr[15:8]};
   assign w_dith = {{(ACC_W-IN_W+12){w_d[8]}}, w_d, {(IN_W-20){1'b0}}};
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_lfsr <= 32'hACE1_2468;
      else if (dsm_stb_i) r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
`else
   assign w_dith = '0;
`endif

   // Sums carry one guard bit; overflow shows as the top two bits disagreeing.
   always_comb begin
      w_x = '0;
      w_fb = '0;
      w_s1 = '0;
      w_s2 = '0;
      w_o1 = '0;
      w_o2 = '0;
      w_n1 = '0;
      w_n2 = '0;
      for (int c = 0; c < 2; c++) begin
         w_x[c]  = mute_i ? '0 : {{(ACC_W+2-IN_W){r_hold[c][IN_W-1]}}, r_hold[c][IN_W-1:1]} + w_dith;
         w_fb[c] = r_dsm[c] ? FS : -FS;
         w_s1[c] = {r_i1[c][ACC_W-1], r_i1[c]} + w_x[c] - w_fb[c];
         w_s2[c] = {r_i2[c][ACC_W-1], r_i2[c]} + {r_i1[c][ACC_W-1], r_i1[c]} - w_fb[c];
         w_o1[c] = w_s1[c][ACC_W] ^ w_s1[c][ACC_W-1];
         w_o2[c] = w_s2[c][ACC_W] ^ w_s2[c][ACC_W-1];
         w_n1[c] = w_o1[c] ? {w_s1[c][ACC_W], {(ACC_W-1){~w_s1[c][ACC_W]}}} : w_s1[c][ACC_W-1:0];
         w_n2[c] = w_o2[c] ? {w_s2[c][ACC_W], {(ACC_W-1){~w_s2[c][ACC_W]}}} : w_s2[c][ACC_W-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_hold  <= '0;
         r_i1    <= '0;
         r_i2    <= '0;
         r_dsm   <= '0;
         r_ovl   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= dsm_stb_i;
         for (int c = 0; c < 2; c++) begin
            if (w_cap[c]) r_hold[c] <= w_data[c][31 -: IN_W];
            if (dsm_stb_i) begin
               r_i1[c]  <= w_n1[c];
               r_i2[c]  <= w_n2[c];
               r_dsm[c] <= ~w_n2[c][ACC_W-1];
               r_ovl[c] <= r_ovl[c] | w_o1[c] | w_o2[c];
            end
         end
      end

   assign dsm_o       = r_dsm;
   assign dsm_valid_o = r_valid;
   assign ovl_o       = r_ovl;
endmodule

// File: tb/tb_pcm_dsm_stereo.sv
// tb_pcm_dsm_stereo: scoreboard bench; driver pushes model predictions, monitor pops on dsm_valid_o.
module tb_pcm_dsm_stereo;
   localparam longint FS   = 64'sd1 << 23;
   localparam longint AMAX = (64'sd1 << 27) - 1;
   localparam longint AMIN = -(64'sd1 << 27);

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic [31:0] data_l_i = '0, data_r_i = '0;
   logic        data_l_stb_i = 1'b0, data_r_stb_i = 1'b0, dsm_stb_i = 1'b0, mute_i = 1'b0;
   logic [1:0]  dsm_o, ovl_o;
   logic        dsm_valid_o;

   pcm_dsm_stereo dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .data_l_i(data_l_i), .data_l_stb_i(data_l_stb_i),
      .data_r_i(data_r_i), .data_r_stb_i(data_r_stb_i),
      .dsm_stb_i(dsm_stb_i), .mute_i(mute_i),
      .dsm_o(dsm_o), .dsm_valid_o(dsm_valid_o), .ovl_o(ovl_o)
   );

   always #5 clk_i = ~clk_i;

   logic [3:0] expq[$];
   logic [1:0] hist[$];
   int tests = 0, fails = 0;
   longint mi1[2], mi2[2];
   bit     mb[2], movl[2];
   int     mh[2];
   bit [31:0] mlfsr;

   task automatic chk(input string nm, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic chk_rng(input string nm, input longint v, input longint lo, input longint hi);
      tests++;
      if (v < lo || v > hi) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d..%0d", nm, v, lo, hi);
      end
   endtask

   task automatic reset_model();
      for (int c = 0; c < 2; c++) begin
         mi1[c] = 0; mi2[c] = 0; mb[c] = 0; movl[c] = 0; mh[c] = 0;
      end
      mlfsr = 32'hACE1_2468;
      expq.delete();
   endtask

   task automatic model_step(input bit m);
      longint x, d, fb, a, b;
      d = 0;
`ifdef DSM_DITHER_EN
      d = (longint'(mlfsr[7:0]) - longint'(mlfsr[15:8])) * 16;
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 32'h8020_0003) : (mlfsr >> 1);
`endif
      for (int c = 0; c < 2; c++) begin
         x  = m ? 0 : longint'(mh[c] >>> 1) + d;
         fb = mb[c] ? FS : -FS;
         a  = mi1[c] + x - fb;
         b  = mi2[c] + mi1[c] - fb;
         if (a > AMAX) begin a = AMAX; movl[c] = 1; end
         if (a < AMIN) begin a = AMIN; movl[c] = 1; end
         if (b > AMAX) begin b = AMAX; movl[c] = 1; end
         if (b < AMIN) begin b = AMIN; movl[c] = 1; end
         mi1[c] = a;
         mi2[c] = b;
         mb[c]  = (b >= 0);
      end
      expq.push_back({movl[1], movl[0], mb[1], mb[0]});
   endtask

   // One clock of stimulus; the model sees the old hold when a capture coincides with an update.
   task automatic drive(input bit stb, input bit m, input bit ls, input logic [31:0] l,
                        input bit rs, input logic [31:0] r);
      @(negedge clk_i);
      dsm_stb_i = stb; mute_i = m;
      data_l_stb_i = ls; data_l_i = l;
      data_r_stb_i = rs; data_r_i = r;
      if (stb) model_step(m);
      if (ls) mh[0] = $signed(l) >>> 8;
      if (rs) mh[1] = $signed(r) >>> 8;
   endtask

   task automatic run(input int n, input int gap, input bit m);
      for (int i = 0; i < n; i++) begin
         drive(1, m, 0, 0, 0, 0);
         for (int g = 1; g < gap; g++) drive(0, m, 0, 0, 0, 0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   function automatic int ones(input int ch, input int start);
      int n = 0;
      for (int i = start; i < hist.size(); i++) n += int'(hist[i][ch]);
      return n;
   endfunction

   function automatic logic [7:0] first8(input int ch);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], hist[i][ch]};
      return v;
   endfunction

   always @(negedge clk_i)
      if (dsm_valid_o) begin
         if (expq.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            logic [3:0] e;
            e = expq.pop_front();
            chk("dsm_o", dsm_o, e[1:0]);
            chk("ovl_o", ovl_o, e[3:2]);
         end
         hist.push_back(dsm_o);
      end

   initial begin
      logic [7:0] pu_l, pu_r;
      reset_model();
      repeat (3) @(negedge clk_i);
      chk("reset_dsm", dsm_o, 0);
      chk("reset_valid", dsm_valid_o, 0);
      chk("reset_ovl", ovl_o, 0);
      rst_i = 1'b0;

      hist.delete();
      run(1024, 16, 0);
      drain();
      chk("idle_valid_count", hist.size(), 1024);
      pu_l = first8(0);
      pu_r = first8(1);
`ifndef DSM_DITHER_EN
      chk("idle_first8_l", pu_l, 8'hE1);
      chk("idle_first8_r", pu_r, 8'hE1);
      chk_rng("idle_ones_l", ones(0, 0), 510, 514);
      chk_rng("idle_ones_r", ones(1, 0), 510, 514);
`endif
      chk("idle_ovl", ovl_o, 0);

      drive(0, 0, 1, 32'h2000_0000, 1, 32'hE000_0000);
      hist.delete();
      run(4096, 2, 0);
      drain();
      chk_rng("quarter_ones_l", ones(0, 0), 2284, 2324);
      chk_rng("quarter_ones_r", ones(1, 0), 1772, 1812);
      chk("quarter_ovl", ovl_o, 0);

      drive(0, 0, 1, 32'h7FFF_FFFF, 0, 0);
      hist.delete();
      run(4096, 1, 0);
      drain();
      chk_rng("fullscale_ones_l", ones(0, 0), 3032, 4095);

      drive(1, 0, 1, 32'h4000_0000, 0, 0);
      run(6, 3, 0);
      drain();

      hist.delete();
      run(2048, 2, 1);
      drain();
      chk_rng("mute_ones_l", ones(0, 1024), 502, 522);
      chk_rng("mute_ones_r", ones(1, 1024), 502, 522);

      drive(0, 0, 0, 0, 1, 32'h9000_0000);
      run(10, 2, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_i = 1'b1;
      #1;
      chk("async_reset_dsm", dsm_o, 0);
      chk("async_reset_valid", dsm_valid_o, 0);
      chk("async_reset_ovl", ovl_o, 0);
      reset_model();
      @(negedge clk_i);
      rst_i = 1'b0;
      hist.delete();
      run(8, 2, 0);
      drain();
      chk("post_reset_first8_l", first8(0), pu_l);
      chk("post_reset_first8_r", first8(1), pu_r);

`ifdef DSM_DITHER_EN
      begin
         int tones = 0;
         hist.delete();
         run(8192, 1, 0);
         drain();
         for (int p = 1; p <= 64; p++) begin
            bit rep = 1;
            for (int k = hist.size() - 2048; k < hist.size(); k++)
               if (hist[k] != hist[k-p]) rep = 0;
            tones += int'(rep);
         end
         chk("dither_idle_tones", tones, 0);
      end
`endif

      chk("scoreboard_empty", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
